pipe_fetch: RTL and testbench
=============================

# pipe_fetch

Instruction-fetch stage that drives the IF/ID pipeline register. Holds the program counter, issues instruction-memory requests over a req/ready handshake, and presents `pc4`/`ins` to IF/ID each cycle. Obeys the decode stage's PC-write enable (`wpcir`) and next-PC select (`pcsource`). Remembers a branch/jump redirect that arrives while a fetch is still outstanding, so the redirect survives a slow memory.

## Interface
Reset is asynchronous and active-high on port `reset`; the single clock is `clock`.

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.

Ports:
- `clock` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wpcir` in 1: PC/IR write enable from hazard logic; 0 = stall.
- `pcsource` in 2: next-PC select. 00 = pc+4, 01 = `bpc`, 10 = `da`, 11 = `jpc`.
- `bpc` in 32: branch target.
- `da` in 32: register jump target (jr).
- `jpc` in 32: jump target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_ready` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `pc4` out 32: `pc` + 4 of the presented instruction, to IF/ID.
- `ins` out 32: presented instruction, to IF/ID. 32'h0 (NOP) when no instruction is available.

## Operation
- State:
  - `pc` (32)
  - FSM {FETCH, HOLD}
  - `buf` (32)
  - `redir_valid` (1) and `redir_pc` (32)
- Reset values: `pc` = `RESET_PC`, FSM = FETCH, `buf` = 0, `redir_valid` = 0, `redir_pc` = 0.
- `imem_req` is 0 while `reset` is asserted.
- `npc`:
  - `redir_pc` when `redir_valid` = 1.
  - Otherwise the `pcsource` mux.
  - pc+4 is computed mod 2^32; wrap from 32'hFFFF_FFFC gives 0.
- FETCH state:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - `ins` = `imem_ready` ? `imem_rdata` : 0.
  - On `imem_ready` & `wpcir`: `pc` <= `npc`, `redir_valid` <= 0, stay in FETCH.
  - On `imem_ready` & !`wpcir`: `buf` <= `imem_rdata`, go to HOLD; `pc` unchanged.
  - On !`imem_ready` & `wpcir` & `pcsource` != 00 & !`redir_valid`: `redir_valid` <= 1 and `redir_pc` <= the mux value. ID receives a NOP, so the redirect must be kept.
  - On !`imem_ready` with `redir_valid` already set: any further non-00 `pcsource` is ignored (first redirect wins).
- HOLD state:
  - `imem_req` = 0 and `ins` = `buf`; `imem_ready` is ignored.
  - On `wpcir`: `pc` <= `npc`, `redir_valid` <= 0, go to FETCH.
- `pc4` = `pc` + 4 in every state.
- Delay-slot semantics: a redirect takes effect on the PC *after* the instruction being fetched when it arrived.

## Timing
- Zero-wait memory (`imem_ready` high in the request cycle) gives one instruction per cycle.
- `ins` is combinational from `imem_rdata`; IF/ID samples it on the same edge that `pc` advances.
- N wait cycles give N NOPs to IF/ID (only when `wpcir` = 1); the instruction arrives on cycle N+1.
- Handshake rules:
  - `imem_addr` is stable while `imem_req` = 1 and `imem_ready` = 0.
  - The memory must not assert `imem_ready` without `imem_req`.
- Stall (`wpcir` = 0) together with ready: the instruction is buffered, and no new request is made until the stall releases.
- `reset` asserted mid-fetch: the outstanding fetch is abandoned immediately. The first cycle after deassertion requests `RESET_PC`.

## Structure
- Shared package holds:
  - `PCSRC_SEQ`/`PCSRC_BR`/`PCSRC_JR`/`PCSRC_J` (2'b00..2'b11)
  - `INS_NOP` = 32'h0
  - the FETCH/HOLD state encoding
- Optional sub-module `pipe_npc_mux`: purely combinational 4:1 `pcsource` mux plus the pc+4 adder. Everything else stays in `pipe_fetch`.

## Test plan
- Reset, zero-wait memory, `wpcir` = 1, `pcsource` = 00 → `imem_addr` 0, 4, 8, 12 on consecutive cycles; `pc4` 4, 8, 12, 16; `ins` matches memory.
- 2 wait cycles at `pc` = 8 → `ins` = 0 for two cycles, `imem_addr` stays 8, then the word at 8 is delivered and `imem_addr` goes to 12.
- `pcsource` = 01, `bpc` = 32'h100 during a wait at `pc` = 8 (`wpcir` = 1), then `pcsource` = 00 → after the word at 8 is delivered, `imem_addr` = 32'h100.
- `wpcir` = 0 with ready at `pc` = 16 → state HOLD, `imem_req` = 0, `ins` holds the word at 16 for 3 cycles; on `wpcir` = 1 → `imem_addr` = 20.
- `pcsource` = 10 with `da` = 32'h40 (delivered same cycle) → next `imem_addr` = 32'h40. Repeat with `pcsource` = 11 and `jpc` = 32'h80 → 32'h80.
- Assert `reset` while `imem_req` = 1 and waiting, with `RESET_PC` = 32'h200 → `imem_req` drops immediately; after release, `imem_addr` = 32'h200 and `redir_valid` = 0.

Source files
------------

// File: rtl/pipe_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: next-PC selects, NOP word
// and the FETCH/HOLD state encoding.
package pipe_fetch_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] INS_NOP = 32'h0000_0000;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/pipe_npc_mux.sv
// Combinational next-PC select: pc+4 adder plus the 4:1 pcsource mux.
module pipe_npc_mux
    import pipe_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] pc4,
    output logic [31:0] mux_pc
);

    // Adder width matches pc, so wrap past 32'hFFFF_FFFC falls out naturally.
    assign pc4 = pc + 32'd4;

    always_comb begin
        mux_pc = pc4;
        case (pcsource)
            PCSRC_SEQ: mux_pc = pc4;
            PCSRC_BR:  mux_pc = bpc;
            PCSRC_JR:  mux_pc = da;
            PCSRC_J:   mux_pc = jpc;
            default:   mux_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and
// feeds pc4/ins to IF/ID, keeping a redirect alive across slow fetches.
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] ins
);

    logic [31:0] pc;
    logic [0:0]  state;
    logic [31:0] hold_buf;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] mux_pc;
    logic [31:0] npc;

    pipe_npc_mux u_npc (
        .pc       (pc),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .pc4      (pc4),
        .mux_pc   (mux_pc)
    );

    // A redirect latched during a wait outranks whatever decode shows now.
    assign npc       = redir_valid ? redir_pc : mux_pc;
    assign imem_addr = pc;
    assign imem_req  = !reset && (state == ST_FETCH);

    always_comb begin
        ins = INS_NOP;
        if (state == ST_HOLD)
            ins = hold_buf;
        else if (imem_ready)
            ins = imem_rdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= ST_FETCH;
            hold_buf    <= INS_NOP;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (wpcir) begin
                            pc          <= npc;
                            redir_valid <= 1'b0;
                        end else begin
                            hold_buf <= imem_rdata;
                            state    <= ST_HOLD;
                        end
                    end else if (wpcir && (pcsource != PCSRC_SEQ) && !redir_valid) begin
                        // ID sees a NOP this cycle, so the redirect must be kept.
                        redir_valid <= 1'b1;
                        redir_pc    <= mux_pc;
                    end
                end
                ST_HOLD: begin
                    if (wpcir) begin
                        pc          <= npc;
                        redir_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Scoreboard bench for pipe_fetch: stimulus pushes expected outputs from an
// abstract fetch model, a negedge monitor pops and compares.
module tb_pipe_fetch;

    localparam logic [31:0] RPC = 32'h0000_0200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wpcir = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0, da = 32'h0, jpc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc4;
    logic [31:0] ins;

    pipe_fetch #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .da(da), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc4(pc4), .ins(ins)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Abstract model: the PC, an optional parked instruction, an optional pending target.
    logic [31:0] m_pc = RPC;
    logic [31:0] parked[$];
    logic [31:0] pending[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step(input logic r, input logic rdy, input logic w, input logic [1:0] ps,
                        input logic [31:0] b, input logic [31:0] d, input logic [31:0] j);
        exp_t e;
        logic [31:0] sel;
        logic rdy_eff;
        if (r) begin
            m_pc = RPC;
            parked.delete();
            pending.delete();
        end
        // The memory only answers an outstanding request.
        rdy_eff = rdy && !r && (parked.size() == 0);
        reset = r; wpcir = w; pcsource = ps; bpc = b; da = d; jpc = j;
        imem_ready = rdy_eff;
        imem_rdata = rdy_eff ? memfn(m_pc) : $urandom;
        e.req  = !r && (parked.size() == 0);
        e.addr = m_pc;
        e.pc4  = m_pc + 32'd4;
        if (parked.size() != 0) e.ins = parked[0];
        else                    e.ins = rdy_eff ? memfn(m_pc) : 32'h0;
        exp_q.push_back(e);
        @(posedge clock);
        if (!r) begin
            case (ps)
                2'b01:   sel = b;
                2'b10:   sel = d;
                2'b11:   sel = j;
                default: sel = m_pc + 32'd4;
            endcase
            if (pending.size() != 0) sel = pending[0];
            if (parked.size() != 0) begin
                if (w) begin
                    m_pc = sel;
                    parked.delete();
                    pending.delete();
                end
            end else if (rdy_eff) begin
                if (w) begin
                    m_pc = sel;
                    pending.delete();
                end else begin
                    parked.push_back(memfn(m_pc));
                end
            end else if (w && ps != 2'b00 && pending.size() == 0) begin
                pending.push_back(sel);
            end
        end
        #1;
    endtask

    task automatic seq(input logic rdy, input logic w);
        step(1'b0, rdy, w, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (imem_req !== e.req || imem_addr !== e.addr || pc4 !== e.pc4 || ins !== e.ins) begin
                n_fail++;
                $display("FAIL cycle%0d: got req=%b addr=%h pc4=%h ins=%h, want req=%b addr=%h pc4=%h ins=%h",
                         n_tests, imem_req, imem_addr, pc4, ins, e.req, e.addr, e.pc4, e.ins);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state is observed while reset is held.
        @(posedge clock); #1;
        step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        // Zero-wait sequential stream.
        repeat (4) seq(1'b1, 1'b1);
        // Two wait cycles, then delivery.
        seq(1'b0, 1'b1); seq(1'b0, 1'b1); seq(1'b1, 1'b1);
        // Branch arrives during a wait, pcsource returns to 00 before delivery.
        step(1'b0, 1'b0, 1'b1, 2'b01, 32'h100, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h999C);
        seq(1'b0, 1'b1); seq(1'b1, 1'b1); seq(1'b1, 1'b1);
        // Stall with ready: instruction parked for three cycles, then release.
        seq(1'b1, 1'b0); seq(1'b1, 1'b0); seq(1'b1, 1'b0); seq(1'b1, 1'b1); seq(1'b1, 1'b1);
        // Same-cycle jr and j redirects.
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h40, 32'h0);
        seq(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'h0, 32'h0, 32'h80);
        seq(1'b1, 1'b1);
        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 1'b1, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFF8);
        seq(1'b1, 1'b1); seq(1'b1, 1'b1); seq(1'b1, 1'b1);
        // Reset while a fetch with a pending redirect is outstanding.
        step(1'b0, 1'b0, 1'b1, 2'b01, 32'h3000, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0);
        seq(1'b0, 1'b1); seq(1'b1, 1'b1); seq(1'b1, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ps;
            ps = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(($urandom_range(0, 150) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0),
                 ps,
                 {$urandom} & 32'hFFFF_FFFC,
                 {$urandom} & 32'hFFFF_FFFC,
                 {$urandom} & 32'hFFFF_FFFC);
        end
        seq(1'b1, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
